// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array edge blocks (feeder, PE, drain).
//   ELEM_W          : default element width used across the array blocks
//   feeder_state_e  : skew feeder control states
package systolic_pkg;

  localparam int unsigned ELEM_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH
  } feeder_state_e;

endpackage

// File: rtl/systolic_skew_feeder_delay.sv
// skew_delay_line: valid+data shift register of depth_p stages for one lane.
// Data entering with valid_i=0 is zeroed so an idle slot always reads zero.
// Ports:
//   clk_i    in  1        clock, rising edge
//   reset_i  in  1        asynchronous, active-low clear of all stages
//   valid_i  in  1        element valid entering the line
//   data_i   in  width_p  element entering the line
//   valid_o  out 1        valid after depth_p cycles
//   data_o   out width_p  element after depth_p cycles
module skew_delay_line #(
  parameter int unsigned width_p = 8,
  parameter int unsigned depth_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               valid_i,
  input  logic [width_p-1:0] data_i,
  output logic               valid_o,
  output logic [width_p-1:0] data_o
);

  logic               vld_p  [depth_p];
  logic [width_p-1:0] data_p [depth_p];

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < int'(depth_p); i++) begin
        vld_p[i]  <= 1'b0;
        data_p[i] <= '0;
      end
    end else begin
      // stage 0: capture, zeroing empty slots
      vld_p[0]  <= valid_i;
      data_p[0] <= valid_i ? data_i : '0;
      // stages 1..depth_p-1: plain shift
      for (int i = 1; i < int'(depth_p); i++) begin
        vld_p[i]  <= vld_p[i-1];
        data_p[i] <= data_p[i-1];
      end
    end
  end

  assign valid_o = vld_p[depth_p-1];
  assign data_o  = data_p[depth_p-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: pops len_p vectors from an upstream fifo (valid/yumi)
// and drives one edge of a systolic array with diagonal skew: lane k shows a
// vector accepted in cycle t during cycle t+1+k. After the last accept the
// skew pipeline is flushed for lanes_p cycles and done_o pulses on the cycle
// the last lane shows its last element.
// Ports:
//   clk_i    in  1                clock, rising edge
//   reset_i  in  1                asynchronous, active-low reset
//   start_i  in  1                begin a tile (only taken in IDLE)
//   valid_i  in  1                fifo has a vector on data_i
//   data_i   in  lanes_p*width_p  vector, lane k at [k*width_p +: width_p]
//   yumi_o   out 1                pop the fifo this cycle
//   valid_o  out lanes_p          per-lane element valid into the array
//   data_o   out lanes_p*width_p  per-lane element, zero when not valid
//   busy_o   out 1                tile in progress
//   done_o   out 1                one-cycle pulse, tile fully delivered
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned width_p = ELEM_W,
  parameter int unsigned lanes_p = 4,
  parameter int unsigned len_p   = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       start_i,
  input  logic                       valid_i,
  input  logic [lanes_p*width_p-1:0] data_i,
  output logic                       yumi_o,
  output logic [lanes_p-1:0]         valid_o,
  output logic [lanes_p*width_p-1:0] data_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int unsigned VEC_W = $clog2(len_p + 1);
  localparam int unsigned FL_W  = $clog2(lanes_p + 1);
  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(len_p - 1);
  localparam logic [FL_W-1:0]  LAST_FL  = FL_W'(lanes_p - 1);

  feeder_state_e    state;
  logic [VEC_W-1:0] vec_cnt;
  logic [FL_W-1:0]  flush_cnt;

  // Pop only while loading; a vector past len_p is never taken.
  assign yumi_o = (state == LOAD) && valid_i;
  assign busy_o = (state != IDLE);
  assign done_o = (state == FLUSH) && (flush_cnt == LAST_FL);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state     <= IDLE;
      vec_cnt   <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            state   <= LOAD;
            vec_cnt <= '0;
          end
        end
        LOAD: begin
          if (valid_i) begin
            vec_cnt <= vec_cnt + VEC_W'(1);
            if (vec_cnt == LAST_VEC) begin
              state     <= FLUSH;
              flush_cnt <= '0;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == LAST_FL) state <= IDLE;
          else                      flush_cnt <= flush_cnt + FL_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Lane k is a delay line of depth k+1 fed by the accepted vector slice.
  for (genvar k = 0; k < int'(lanes_p); k++) begin : g_lane
    skew_delay_line #(
      .width_p(width_p),
      .depth_p(k + 1)
    ) u_delay (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .valid_i(yumi_o),
      .data_i (data_i[k*width_p +: width_p]),
      .valid_o(valid_o[k]),
      .data_o (data_o[k*width_p +: width_p])
    );
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
module tb_systolic_skew_feeder;
  localparam int W = 8;
  localparam int L = 4;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset_i;
  logic           start_i;
  logic           fifo_en;
  logic           valid_i;
  logic [L*W-1:0] data_i;
  logic           yumi_o;
  logic [L-1:0]   valid_o;
  logic [L*W-1:0] data_o;
  logic           busy_o;
  logic           done_o;

  int pops = 0;
  int base = 0;
  int fifo_cnt = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Fifo model: vector i holds lane k = i*4+k+1.
  function automatic logic [L*W-1:0] vec(input int i);
    logic [L*W-1:0] v;
    for (int k = 0; k < L; k++) v[k*W +: W] = 8'(i * 4 + k + 1);
    return v;
  endfunction

  always @(posedge clk) if (yumi_o) pops <= pops + 1;
  assign data_i  = vec(pops - base);
  assign valid_i = fifo_en && ((pops - base) < fifo_cnt);

  // Expected lane k element in cycle c given the accept cycles of vectors first..first+3.
  function automatic logic [W-1:0] exp_lane(input int acc[N], input int c, input int k,
                                            input int first);
    for (int j = 0; j < N; j++)
      if (acc[j] + 1 + k == c) return 8'((first + j) * 4 + k + 1);
    return 8'h00;
  endfunction

  systolic_skew_feeder #(.width_p(W), .lanes_p(L), .len_p(N)) dut (
    .clk_i  (clk),
    .reset_i(reset_i),
    .start_i(start_i),
    .valid_i(valid_i),
    .data_i (data_i),
    .yumi_o (yumi_o),
    .valid_o(valid_o),
    .data_o (data_o),
    .busy_o (busy_o),
    .done_o (done_o)
  );

  task automatic test_reset();
    reset_i = 1'b0; start_i = 1'b0; fifo_en = 1'b1; base = pops; fifo_cnt = 4;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (yumi_o !== 1'b0) begin errors++; $display("FAIL reset_yumi got %b exp 0", yumi_o); end
    checks++; if (valid_o !== '0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_o); end
    checks++; if (data_o !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", data_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done_o); end
    @(negedge clk);
    reset_i = 1'b1;
  endtask

  task automatic test_basic();
    int acc[N] = '{1, 2, 3, 4};
    base = pops; fifo_cnt = 4; fifo_en = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      start_i = (c == 0);
      #1;
      checks++;
      if (yumi_o !== (c >= 1 && c <= 4)) begin errors++; $display("FAIL basic_yumi c=%0d got %b", c, yumi_o); end
      for (int k = 0; k < L; k++) begin
        logic [W-1:0] e;
        e = exp_lane(acc, c, k, 0);
        checks++;
        if (data_o[k*W +: W] !== e || valid_o[k] !== (e != 0)) begin
          errors++;
          $display("FAIL basic_lane%0d c=%0d got %b/%h exp %b/%h", k, c, valid_o[k], data_o[k*W +: W], e != 0, e);
        end
      end
      checks++;
      if (done_o !== (c == 8)) begin errors++; $display("FAIL basic_done c=%0d got %b", c, done_o); end
      checks++;
      if (busy_o !== (c >= 1 && c <= 8)) begin errors++; $display("FAIL basic_busy c=%0d got %b", c, busy_o); end
    end
    start_i = 1'b0;
  endtask

  task automatic test_bubble();
    int acc[N] = '{1, 4, 5, 6};
    base = pops; fifo_cnt = 4;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      start_i = (c == 0);
      fifo_en = !(c == 2 || c == 3);
      #1;
      checks++;
      if (yumi_o !== (c == 1 || (c >= 4 && c <= 6))) begin errors++; $display("FAIL bubble_yumi c=%0d got %b", c, yumi_o); end
      for (int k = 0; k < L; k++) begin
        logic [W-1:0] e;
        e = exp_lane(acc, c, k, 0);
        checks++;
        if (data_o[k*W +: W] !== e || valid_o[k] !== (e != 0)) begin
          errors++;
          $display("FAIL bubble_lane%0d c=%0d got %b/%h exp %b/%h", k, c, valid_o[k], data_o[k*W +: W], e != 0, e);
        end
      end
      checks++;
      if (done_o !== (c == 10)) begin errors++; $display("FAIL bubble_done c=%0d got %b", c, done_o); end
      checks++;
      if (busy_o !== (c >= 1 && c <= 10)) begin errors++; $display("FAIL bubble_busy c=%0d got %b", c, busy_o); end
    end
    start_i = 1'b0; fifo_en = 1'b1;
  endtask

  task automatic test_overfull();
    int npop = 0;
    base = pops; fifo_cnt = 5; fifo_en = 1'b1;
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      start_i = (c == 0);
      #1;
      if (yumi_o === 1'b1) npop++;
    end
    start_i = 1'b0;
    checks++; if (npop != 4) begin errors++; $display("FAIL overfull_pops got %0d exp 4", npop); end
    checks++; if (valid_i !== 1'b1) begin errors++; $display("FAIL overfull_head_valid got %b exp 1", valid_i); end
    checks++; if (data_i !== 32'h14131211) begin errors++; $display("FAIL overfull_head_data got %h exp 14131211", data_i); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL overfull_busy got %b exp 0", busy_o); end
  endtask

  task automatic test_start_ignored();
    base = pops; fifo_cnt = 4; fifo_en = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      start_i = (c == 0 || c == 3 || c == 8);
      #1;
      checks++;
      if (yumi_o !== (c >= 1 && c <= 4)) begin errors++; $display("FAIL ign_yumi c=%0d got %b", c, yumi_o); end
      checks++;
      if (busy_o !== (c >= 1 && c <= 8)) begin errors++; $display("FAIL ign_busy c=%0d got %b", c, busy_o); end
      checks++;
      if (done_o !== (c == 8)) begin errors++; $display("FAIL ign_done c=%0d got %b", c, done_o); end
    end
    start_i = 1'b0;
  endtask

  task automatic test_mid_reset();
    base = pops; fifo_cnt = 8; fifo_en = 1'b1;
    for (int c = 0; c <= 19; c++) begin
      @(negedge clk);
      start_i = (c == 0 || c == 10);
      if (c == 3) reset_i = 1'b0;
      if (c == 5) reset_i = 1'b1;
      #1;
      if (c == 3) begin
        checks++; if (valid_o !== '0) begin errors++; $display("FAIL mrst_valid got %b exp 0", valid_o); end
        checks++; if (data_o !== '0) begin errors++; $display("FAIL mrst_data got %h exp 0", data_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mrst_busy got %b exp 0", busy_o); end
      end
      if (c >= 3 && c <= 9) begin
        checks++;
        if (done_o !== 1'b0 || yumi_o !== 1'b0) begin
          errors++; $display("FAIL mrst_idle c=%0d got done %b yumi %b exp 0 0", c, done_o, yumi_o);
        end
      end
      if (c == 11) begin
        checks++; if (yumi_o !== 1'b1) begin errors++; $display("FAIL mrst_restart_yumi got %b exp 1", yumi_o); end
        checks++; if (data_i !== 32'h0C0B0A09) begin errors++; $display("FAIL mrst_head got %h exp 0c0b0a09", data_i); end
      end
      if (c == 12) begin
        checks++;
        if (valid_o[0] !== 1'b1 || data_o[W-1:0] !== 8'h09) begin
          errors++; $display("FAIL mrst_lane0 got %b/%h exp 1/09", valid_o[0], data_o[W-1:0]);
        end
      end
      if (c >= 11) begin
        checks++;
        if (done_o !== (c == 18)) begin errors++; $display("FAIL mrst_done c=%0d got %b", c, done_o); end
      end
    end
    start_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b0; start_i = 1'b0; fifo_en = 1'b0;
    test_reset();
    test_basic();
    test_bubble();
    test_overfull();
    test_start_ignored();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
